// File: rtl/emaxi_req_arb.sv
// Two-port emesh request arbiter in front of emaxi: independent wr/rd arbitration with a
// registered output stage per channel, plus a read-tag FIFO that routes responses back.
// Define EMAXI_ARB_FIXED_PRIO_EN for fixed req0-first priority instead of round-robin.
module emaxi_req_arb #(
   parameter int PW     = 104,
   parameter int RDEPTH = 4
) (
   input  logic                         axi_aclk,
   input  logic                         axi_areset,
   input  logic                         req0_wr_access,
   input  logic [PW-1:0]                req0_wr_packet,
   output logic                         req0_wr_wait,
   input  logic                         req0_rd_access,
   input  logic [PW-1:0]                req0_rd_packet,
   output logic                         req0_rd_wait,
   output logic                         req0_rr_access,
   output logic [PW-1:0]                req0_rr_packet,
   input  logic                         req0_rr_wait,
   input  logic                         req1_wr_access,
   input  logic [PW-1:0]                req1_wr_packet,
   output logic                         req1_wr_wait,
   input  logic                         req1_rd_access,
   input  logic [PW-1:0]                req1_rd_packet,
   output logic                         req1_rd_wait,
   output logic                         req1_rr_access,
   output logic [PW-1:0]                req1_rr_packet,
   input  logic                         req1_rr_wait,
   output logic                         m_wr_access,
   output logic [PW-1:0]                m_wr_packet,
   input  logic                         m_wr_wait,
   output logic                         m_rd_access,
   output logic [PW-1:0]                m_rd_packet,
   input  logic                         m_rd_wait,
   input  logic                         m_rr_access,
   input  logic [PW-1:0]                m_rr_packet,
   output logic                         m_rr_wait,
   output logic [$clog2(RDEPTH+1)-1:0]  rd_outstanding,
   output logic                         rr_err
);

   localparam int CW = $clog2(RDEPTH+1);
   localparam int AW = $clog2(RDEPTH);

   logic          r_wr_vld, r_rd_vld;
   logic [PW-1:0] r_wr_pkt, r_rd_pkt;
   logic          w_wr_load, w_wr_prio, w_wr_gnt1, w_wr_take;
   logic          w_rd_load, w_rd_open, w_rd_prio, w_rd_gnt1, w_rd_take;
   logic [RDEPTH-1:0] r_tag;
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_full, w_empty, w_head, w_push, w_pop;

   // Wait depends only on the other requester's access, so a requester's own access never loops back.
   assign w_wr_load    = !r_wr_vld || !m_wr_wait;
   assign w_wr_gnt1    = req1_wr_access && (!req0_wr_access || w_wr_prio);
   assign w_wr_take    = w_wr_load && (req0_wr_access || req1_wr_access);
   assign req0_wr_wait = !(w_wr_load && (!req1_wr_access || !w_wr_prio));
   assign req1_wr_wait = !(w_wr_load && (!req0_wr_access ||  w_wr_prio));

   // A full tag FIFO blocks new read grants but the output register still drains.
   assign w_rd_load    = !r_rd_vld || !m_rd_wait;
   assign w_rd_open    = w_rd_load && !w_full;
   assign w_rd_gnt1    = req1_rd_access && (!req0_rd_access || w_rd_prio);
   assign w_rd_take    = w_rd_open && (req0_rd_access || req1_rd_access);
   assign req0_rd_wait = !(w_rd_open && (!req1_rd_access || !w_rd_prio));
   assign req1_rd_wait = !(w_rd_open && (!req0_rd_access ||  w_rd_prio));

`ifdef EMAXI_ARB_FIXED_PRIO_EN
   assign w_wr_prio = 1'b0;
   assign w_rd_prio = 1'b0;
`else
   logic r_wr_prio, r_rd_prio;
   logic w_wr_both, w_rd_both;

   assign w_wr_both = req0_wr_access && req1_wr_access;
   assign w_rd_both = req0_rd_access && req1_rd_access;
   assign w_wr_prio = r_wr_prio;
   assign w_rd_prio = r_rd_prio;

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_wr_prio <= 1'b0;
         r_rd_prio <= 1'b0;
      end else begin
         if (w_wr_load && w_wr_both) r_wr_prio <= !r_wr_prio;
         if (w_rd_open && w_rd_both) r_rd_prio <= !r_rd_prio;
      end
   end
`endif

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_wr_vld <= 1'b0;
         r_wr_pkt <= '0;
         r_rd_vld <= 1'b0;
         r_rd_pkt <= '0;
      end else begin
         if (w_wr_load) begin
            r_wr_vld <= w_wr_take;
            if (w_wr_take) r_wr_pkt <= w_wr_gnt1 ? req1_wr_packet : req0_wr_packet;
         end
         if (w_rd_load) begin
            r_rd_vld <= w_rd_take;
            if (w_rd_take) r_rd_pkt <= w_rd_gnt1 ? req1_rd_packet : req0_rd_packet;
         end
      end
   end

   assign m_wr_access = r_wr_vld;
   assign m_wr_packet = r_wr_pkt;
   assign m_rd_access = r_rd_vld;
   assign m_rd_packet = r_rd_pkt;

   // Tag FIFO: one bit per outstanding read naming the requester that issued it.
   assign w_full  = (r_cnt == CW'(RDEPTH));
   assign w_empty = (r_cnt == '0);
   assign w_head  = r_tag[r_rp];
   assign w_push  = w_rd_take;
   assign w_pop   = m_rr_access && !m_rr_wait && !w_empty;

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_tag  <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         rr_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_tag[r_wp] <= w_rd_gnt1;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (m_rr_access && w_empty) rr_err <= 1'b1;
      end
   end

   assign rd_outstanding = r_cnt;
   assign req0_rr_access = m_rr_access && !w_empty && !w_head;
   assign req1_rr_access = m_rr_access && !w_empty &&  w_head;
   assign req0_rr_packet = m_rr_packet;
   assign req1_rr_packet = m_rr_packet;
   // An empty FIFO swallows the response so emaxi never stalls on an orphan.
   assign m_rr_wait      = !w_empty && (w_head ? req1_rr_wait : req0_rr_wait);

endmodule

// File: tb/tb_emaxi_req_arb.sv
// Scoreboard bench for emaxi_req_arb: directed stimulus pushes expected transfers,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_emaxi_req_arb;
   localparam int PW = 104;
   localparam int RDEPTH = 4;

   typedef struct { logic port; logic [PW-1:0] pkt; } rr_t;

   logic clk = 1'b0;
   logic rst;
   logic req0_wr_access, req1_wr_access, req0_rd_access, req1_rd_access;
   logic [PW-1:0] req0_wr_packet, req1_wr_packet, req0_rd_packet, req1_rd_packet;
   logic req0_wr_wait, req1_wr_wait, req0_rd_wait, req1_rd_wait;
   logic req0_rr_access, req1_rr_access, req0_rr_wait, req1_rr_wait;
   logic [PW-1:0] req0_rr_packet, req1_rr_packet;
   logic m_wr_access, m_wr_wait, m_rd_access, m_rd_wait, m_rr_access, m_rr_wait;
   logic [PW-1:0] m_wr_packet, m_rd_packet, m_rr_packet;
   logic [$clog2(RDEPTH+1)-1:0] rd_outstanding;
   logic rr_err;

   int n_cmp = 0;
   int n_err = 0;
   logic [PW-1:0] wr_q[$];
   logic [PW-1:0] rd_q[$];
   rr_t rr_q[$];

   always #5 clk = ~clk;

   emaxi_req_arb #(.PW(PW), .RDEPTH(RDEPTH)) dut (
      .axi_aclk(clk), .axi_areset(rst),
      .req0_wr_access(req0_wr_access), .req0_wr_packet(req0_wr_packet), .req0_wr_wait(req0_wr_wait),
      .req0_rd_access(req0_rd_access), .req0_rd_packet(req0_rd_packet), .req0_rd_wait(req0_rd_wait),
      .req0_rr_access(req0_rr_access), .req0_rr_packet(req0_rr_packet), .req0_rr_wait(req0_rr_wait),
      .req1_wr_access(req1_wr_access), .req1_wr_packet(req1_wr_packet), .req1_wr_wait(req1_wr_wait),
      .req1_rd_access(req1_rd_access), .req1_rd_packet(req1_rd_packet), .req1_rd_wait(req1_rd_wait),
      .req1_rr_access(req1_rr_access), .req1_rr_packet(req1_rr_packet), .req1_rr_wait(req1_rr_wait),
      .m_wr_access(m_wr_access), .m_wr_packet(m_wr_packet), .m_wr_wait(m_wr_wait),
      .m_rd_access(m_rd_access), .m_rd_packet(m_rd_packet), .m_rd_wait(m_rd_wait),
      .m_rr_access(m_rr_access), .m_rr_packet(m_rr_packet), .m_rr_wait(m_rr_wait),
      .rd_outstanding(rd_outstanding), .rr_err(rr_err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every completed transfer on an output must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_wr_access && !m_wr_wait) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 128'(m_wr_packet), 128'h0);
            else chk("m_wr_packet", 128'(m_wr_packet), 128'(wr_q.pop_front()));
         end
         if (m_rd_access && !m_rd_wait) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 128'(m_rd_packet), 128'h0);
            else chk("m_rd_packet", 128'(m_rd_packet), 128'(rd_q.pop_front()));
         end
         if ((req0_rr_access && !req0_rr_wait) || (req1_rr_access && !req1_rr_wait)) begin
            chk("rr_onehot", 128'(req0_rr_access && req1_rr_access), 128'h0);
            if (rr_q.size() == 0) chk("rr_unexpected", 128'(req1_rr_access), 128'h2);
            else begin
               rr_t e;
               e = rr_q.pop_front();
               chk("rr_port", 128'(req1_rr_access), 128'(e.port));
               chk("rr_packet", 128'(e.port ? req1_rr_packet : req0_rr_packet), 128'(e.pkt));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] p0, p1;
      logic g[4];
      logic src[4];
      src = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef EMAXI_ARB_FIXED_PRIO_EN
      g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      // Reset with everything active
      rst = 1'b1;
      req0_wr_access = 1; req1_wr_access = 1; req0_rd_access = 1; req1_rd_access = 1;
      req0_wr_packet = 'h11; req1_wr_packet = 'h22; req0_rd_packet = 'h33; req1_rd_packet = 'h44;
      req0_rr_wait = 1; req1_rr_wait = 1; m_wr_wait = 1; m_rd_wait = 1;
      m_rr_access = 1; m_rr_packet = 'h55;
      tick(); tick();
      @(negedge clk);
      chk("rst_m_wr_access", 128'(m_wr_access), 128'h0);
      chk("rst_m_rd_access", 128'(m_rd_access), 128'h0);
      chk("rst_m_wr_packet", 128'(m_wr_packet), 128'h0);
      chk("rst_m_rd_packet", 128'(m_rd_packet), 128'h0);
      chk("rst_rd_outstanding", 128'(rd_outstanding), 128'h0);
      chk("rst_rr_err", 128'(rr_err), 128'h0);
      tick();
      rst = 1'b0;
      req0_rd_access = 0; req1_rd_access = 0; m_rr_access = 0;
      req0_rr_wait = 0; req1_rr_wait = 0; m_wr_wait = 0; m_rd_wait = 0;
      p0 = 'h100; p1 = 'h200;
      req0_wr_packet = p0; req1_wr_packet = p1;

      // Contested writes; first grant after reset goes to req0
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("contest_wr_wait0", 128'(req0_wr_wait), 128'(g[i] != 1'b0));
         chk("contest_wr_wait1", 128'(req1_wr_wait), 128'(g[i] != 1'b1));
         wr_q.push_back(g[i] ? p1 : p0);
         tick();
         if (g[i]) p1 = p1 + 1; else p0 = p0 + 1;
         req0_wr_packet = p0; req1_wr_packet = p1;
      end
      req0_wr_access = 0; req1_wr_access = 0;
      @(negedge clk);
      tick();

      // Write backpressure
      req0_wr_access = 1; req0_wr_packet = 'h300;
      @(negedge clk);
      chk("bp_wr_wait0_idle", 128'(req0_wr_wait), 128'h0);
      wr_q.push_back('h300);
      tick();
      m_wr_wait = 1;
      req0_wr_packet = 'h301; req1_wr_access = 1; req1_wr_packet = 'h401;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_m_wr_access", 128'(m_wr_access), 128'h1);
         chk("bp_m_wr_packet", 128'(m_wr_packet), 128'h300);
         chk("bp_wr_wait0", 128'(req0_wr_wait), 128'h1);
         chk("bp_wr_wait1", 128'(req1_wr_wait), 128'h1);
         tick();
      end
      m_wr_wait = 0;
      @(negedge clk);
      chk("bp_rel_wait0", 128'(req0_wr_wait), 128'h0);
      chk("bp_rel_wait1", 128'(req1_wr_wait), 128'h1);
      wr_q.push_back('h301);
      tick();
      req0_wr_access = 0;
      @(negedge clk);
      chk("bp_rel_wait1b", 128'(req1_wr_wait), 128'h0);
      wr_q.push_back('h401);
      tick();
      req1_wr_access = 0;
      @(negedge clk);
      tick();

      // Read routing: fill the tag FIFO with 1,0,1,0
      for (int i = 0; i < 4; i++) begin
         req0_rd_access = !src[i]; req1_rd_access = src[i];
         req0_rd_packet = PW'('h510 + 16 * i); req1_rd_packet = PW'('h510 + 16 * i);
         @(negedge clk);
         chk("rd_fill_wait", 128'(src[i] ? req1_rd_wait : req0_rd_wait), 128'h0);
         rd_q.push_back(PW'('h510 + 16 * i));
         tick();
      end
      req0_rd_access = 1; req1_rd_access = 1;
      req0_rd_packet = 'h550; req1_rd_packet = 'h560;
      @(negedge clk);
      chk("full_outstanding", 128'(rd_outstanding), 128'h4);
      chk("full_rd_wait0", 128'(req0_rd_wait), 128'h1);
      chk("full_rd_wait1", 128'(req1_rd_wait), 128'h1);
      tick();
      @(negedge clk);
      chk("full_drained", 128'(m_rd_access), 128'h0);
      chk("full_outstanding2", 128'(rd_outstanding), 128'h4);
      tick();
      req0_rd_access = 0; req1_rd_access = 0;

      // Four responses routed back in tag order
      for (int i = 0; i < 4; i++) begin
         m_rr_access = 1; m_rr_packet = PW'('hA0 + i);
         @(negedge clk);
         chk("rr_m_wait", 128'(m_rr_wait), 128'h0);
         rr_q.push_back('{port: src[i], pkt: PW'('hA0 + i)});
         tick();
      end
      m_rr_access = 0;
      @(negedge clk);
      chk("rr_drained_outstanding", 128'(rd_outstanding), 128'h0);
      tick();

      // Response backpressure
      req0_rd_access = 1; req0_rd_packet = 'h600;
      @(negedge clk);
      rd_q.push_back('h600);
      tick();
      req0_rd_access = 0;
      @(negedge clk);
      chk("rbp_outstanding", 128'(rd_outstanding), 128'h1);
      tick();
      m_rr_access = 1; m_rr_packet = 'hB0; req0_rr_wait = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rbp_m_rr_wait", 128'(m_rr_wait), 128'h1);
         chk("rbp_req0_rr_access", 128'(req0_rr_access), 128'h1);
         chk("rbp_hold_outstanding", 128'(rd_outstanding), 128'h1);
         tick();
      end
      req0_rr_wait = 0;
      @(negedge clk);
      chk("rbp_rel_m_rr_wait", 128'(m_rr_wait), 128'h0);
      rr_q.push_back('{port: 1'b0, pkt: PW'('hB0)});
      tick();
      m_rr_access = 0;
      @(negedge clk);
      chk("rbp_pop_outstanding", 128'(rd_outstanding), 128'h0);
      chk("rbp_no_err", 128'(rr_err), 128'h0);
      tick();

      // Spurious response with empty FIFO
      m_rr_access = 1; m_rr_packet = 'hC0;
      @(negedge clk);
      chk("spur_req0_rr_access", 128'(req0_rr_access), 128'h0);
      chk("spur_req1_rr_access", 128'(req1_rr_access), 128'h0);
      chk("spur_m_rr_wait", 128'(m_rr_wait), 128'h0);
      tick();
      m_rr_access = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("spur_rr_err", 128'(rr_err), 128'h1);
         tick();
      end
      rst = 1;
      tick(); tick();
      @(negedge clk);
      chk("rst_clears_rr_err", 128'(rr_err), 128'h0);
      tick();
      rst = 0;
      tick();

      chk("wr_q_empty", 128'(wr_q.size()), 128'h0);
      chk("rd_q_empty", 128'(rd_q.size()), 128'h0);
      chk("rr_q_empty", 128'(rr_q.size()), 128'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
